// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the lsu_rmw load/store unit.
//   - RISC-V funct3 encodings for the supported access sizes
//   - lsu_state_t: control FSM states
//   - is_misaligned / is_illegal: request error classification
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_t;

    // Size is carried in funct3[1:0] for both signed and unsigned variants.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return !(funct3 inside {F3_B, F3_H, F3_W});
        end
        return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for lsu_rmw.
//   word       in   memory word (read data or merge register)
//   addr_lo    in   byte offset within the word
//   funct3     in   access size / signedness
//   wdata      in   right-justified store data
//   load_data  out  lane-selected, sign/zero-extended load value
//   store_word out  word with the addressed lane replaced by wdata
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        // Little-endian: offset 0 is bits [7:0].
        shifted  = word >> {addr_lo, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_HU:   load_data = {16'h0000, sel_half};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            2'b10:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-wide memory without byte enables.
// Sub-word stores are done as a registered read-modify-write.
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_we, req_funct3              store flag and RISC-V funct3
//   req_addr, req_wdata             byte address, right-justified store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion pulse with load data / error
//   mem_we, mem_addr, mem_wdata     memory write port and shared address
//   mem_rdata                       combinational memory read word
// DATA_W must be 32.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              idle;
    logic [DATA_W-1:0] lane_word;
    logic [1:0]        lane_addr;
    logic [2:0]        lane_funct3;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              req_err;

    assign idle = (state_q == IDLE);

    // In IDLE the lane decodes the live request against the live read word
    // (loads finish on accept); afterwards it works on the latched request
    // and the merge register.
    assign lane_word   = idle ? mem_rdata : merge_q;
    assign lane_addr   = idle ? req_addr[1:0] : addr_q[1:0];
    assign lane_funct3 = idle ? req_funct3 : funct3_q;

    lsu_lane u_lane (
        .word       (lane_word),
        .addr_lo    (lane_addr),
        .funct3     (lane_funct3),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign req_err = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else if (!req_we) begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = load_data;
                        state_d     = RESP;
                    end else begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                        // Full words need no merge, so skip the read.
                        state_d     = (req_funct3 == F3_W) ? WR : RD;
                    end
                end
            end
            RD: begin
                merge_d = mem_rdata;
                state_d = WR;
            end
            WR:   state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            merge_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Decoded straight from the state flop so an async reset drops the write at once.
    assign mem_we    = (state_q == WR) && we_q;
    assign mem_addr  = idle ? req_addr : addr_q;
    assign mem_wdata = (state_q == WR) ? store_word : merge_q;

    assign req_ready = idle;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge, tb preload port.
    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;
    int          wr_cnt = 0;
    int          cyc = 0;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_rsp observed=%h expected=no response", rsp_rdata);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = addr[11:2];
        pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Drives a request at a falling edge, holds it until accepted and queues
    // the expected response (lat = cycles from accept edge to response).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        total++;
        assert (req_ready === 1'b1) else begin
            bad++;
            $error("FAIL accept_timeout observed=%b expected=1", req_ready);
        end
        if (req_ready === 1'b1) begin
            acc     = cyc + 1;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = acc + lat - 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, wr_before;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h123;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_addr", mem_addr, 32'h123);
        rst_n = 1'b1;

        preload(32'h40, 32'h8070_F0A5);
        preload(32'h48, 32'h1122_3344);

        // Loads
        issue(1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFF_FFA5, 1'b0, 1, a1); drain();
        issue(1'b0, 3'b100, 32'h41, 32'h0, 32'h0000_00F0, 1'b0, 1, a1); drain();
        issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF_8070, 1'b0, 1, a1); drain();
        issue(1'b0, 3'b101, 32'h42, 32'h0, 32'h0000_8070, 1'b0, 1, a1); drain();
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8070_F0A5, 1'b0, 1, a1); drain();

        // SB read-modify-write, cycle by cycle
        issue(1'b1, 3'b000, 32'h41, 32'h0000_0033, 32'h0, 1'b0, 3, a1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("sb_rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("sb_rd_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("sb_wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sb_wr_wdata", mem_wdata, 32'h8070_33A5);
        chk("sb_wr_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("sb_resp_mem_we", {31'd0, mem_we}, 32'd0);
        chk("sb_resp_ready", {31'd0, req_ready}, 32'd0);
        drain();
        chk("sb_mem", mem[16], 32'h8070_33A5);

        // SH upper half, SW
        issue(1'b1, 3'b001, 32'h4A, 32'h0000_BEEF, 32'h0, 1'b0, 3, a1); drain();
        chk("sh_mem", mem[18], 32'hBEEF_3344);
        issue(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, a1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("sw_wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        drain();
        chk("sw_mem", mem[17], 32'hDEAD_BEEF);

        // Errors never write
        wr_before = wr_cnt;
        issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1, a1); drain();
        issue(1'b1, 3'b001, 32'h43, 32'hFFFF, 32'h0, 1'b1, 1, a1); drain();
        issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1, a1); drain();
        issue(1'b1, 3'b010, 32'h46, 32'h1234_5678, 32'h0, 1'b1, 1, a1); drain();
        issue(1'b1, 3'b100, 32'h40, 32'h55, 32'h0, 1'b1, 1, a1); drain();
        chk("err_write_count", wr_cnt, wr_before);
        chk("err_mem40", mem[16], 32'h8070_33A5);
        chk("err_mem44", mem[17], 32'hDEAD_BEEF);

        // Reset during the WR cycle of an SB
        issue(1'b1, 3'b000, 32'h45, 32'h0000_0077, 32'h0, 1'b0, 3, a1);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_mem_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_mem_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rstwr_ready", {31'd0, req_ready}, 32'd1);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstwr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstwr_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rstwr_mem", mem[17], 32'hDEAD_BEEF);

        // Back-to-back with req_valid held high
        issue(1'b0, 3'b010, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, a1);
        issue(1'b1, 3'b000, 32'h46, 32'h0000_005A, 32'h0, 1'b0, 3, a2);
        issue(1'b0, 3'b010, 32'h44, 32'h0, 32'hDE5A_BEEF, 1'b0, 1, a3);
        drain();
        chk("b2b_gap_lw_sb", a2 - a1, 2);
        chk("b2b_gap_sb_lw", a3 - a2, 4);
        chk("b2b_mem", mem[17], 32'hDE5A_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
